lockin_multi: RTL and testbench

LOCKIN_MULTI -- requirements
Module: lockin_multi

---
 rtl/lockin_pkg.sv | 22 ++
 rtl/lockin_lpf_stage.sv | 29 ++
 rtl/lockin_multi.sv | 204 ++++++++++++++++++++
 tb/tb_lockin_multi.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lockin_pkg.sv
// Shared types, default widths and helpers for the multi-channel lock-in amplifier.
package lockin_pkg;

  localparam int unsigned DEF_N_CH      = 2;
  localparam int unsigned DEF_IN_W      = 16;
  localparam int unsigned DEF_ACC_W     = 32;
  localparam int unsigned DEF_ALPHA_W   = 27;
  localparam int unsigned DEF_MAX_ORDER = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MIX  = 2'd1,
    ST_FILT = 2'd2,
    ST_EMIT = 2'd3
  } state_e;

  // Out-of-range orders fall back to the deepest available stage.
  function automatic int unsigned clamp_order(input int unsigned k, input int unsigned max_order);
    return (k >= max_order) ? (max_order - 1) : k;
  endfunction

endpackage

// File: rtl/lockin_lpf_stage.sv
// Combinational single-pole update y_next = y + ((u - y) * alpha) >>> ALPHA_W.
module lockin_lpf_stage
  import lockin_pkg::*;
#(
  parameter int unsigned ACC_W   = DEF_ACC_W,
  parameter int unsigned ALPHA_W = DEF_ALPHA_W
) (
  input  logic signed [ACC_W-1:0]   u,
  input  logic signed [ACC_W-1:0]   y,
  input  logic        [ALPHA_W-1:0] alpha,
  output logic signed [ACC_W-1:0]   y_next
);

  localparam int unsigned DIFF_W = ACC_W + 1;
  localparam int unsigned PROD_W = DIFF_W + ALPHA_W + 1;

  logic signed [DIFF_W-1:0] diff;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] step;

  // Arithmetic shift floors toward negative infinity; the step never exceeds |u - y|.
  always_comb begin
    diff   = DIFF_W'(u) - DIFF_W'(y);
    prod   = PROD_W'(diff) * PROD_W'($signed({1'b0, alpha}));
    step   = prod >>> ALPHA_W;
    y_next = y + ACC_W'(step);
  end

endmodule

// File: rtl/lockin_multi.sv
// Multi-channel lock-in: one input mixed with N_CH quadrature references, each product
// filtered by a time-multiplexed cascade of one-pole low-pass stages.
module lockin_multi
  import lockin_pkg::*;
#(
  parameter int unsigned N_CH      = DEF_N_CH,
  parameter int unsigned IN_W      = DEF_IN_W,
  parameter int unsigned ACC_W     = DEF_ACC_W,
  parameter int unsigned ALPHA_W   = DEF_ALPHA_W,
  parameter int unsigned MAX_ORDER = DEF_MAX_ORDER,
  localparam int unsigned ORD_W    = (MAX_ORDER > 1) ? $clog2(MAX_ORDER) : 1,
  localparam int unsigned CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                          clk_50MHz,
  input  logic                          rst,
  input  logic signed [IN_W-1:0]        signal_in,
  input  logic [N_CH-1:0][IN_W-1:0]     cos_ref,
  input  logic [N_CH-1:0][IN_W-1:0]     sin_ref,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ORD_W-1:0]              filter_order,
  input  logic [ALPHA_W-1:0]            alpha,
  input  logic                          filter_clear,
  output logic signed [ACC_W-1:0]       X_out,
  output logic signed [ACC_W-1:0]       Y_out,
  output logic [CH_W-1:0]               out_ch,
  output logic                          out_valid
);

  state_e                      state_q, state_d;
  logic [CH_W-1:0]             ch_q, ch_d;
  logic [ORD_W-1:0]            s_q, s_d;
  logic [ORD_W-1:0]            k_q, k_d;
  logic [ALPHA_W-1:0]          alpha_q, alpha_d;
  logic signed [IN_W-1:0]      sig_q, sig_d;
  logic [N_CH-1:0][IN_W-1:0]   cos_q, cos_d;
  logic [N_CH-1:0][IN_W-1:0]   sin_q, sin_d;
  logic signed [ACC_W-1:0]     px_q, px_d;
  logic signed [ACC_W-1:0]     py_q, py_d;
  logic signed [ACC_W-1:0]     yx_q [N_CH][MAX_ORDER];
  logic signed [ACC_W-1:0]     yx_d [N_CH][MAX_ORDER];
  logic signed [ACC_W-1:0]     yy_q [N_CH][MAX_ORDER];
  logic signed [ACC_W-1:0]     yy_d [N_CH][MAX_ORDER];
  logic signed [ACC_W-1:0]     x_out_q, x_out_d;
  logic signed [ACC_W-1:0]     y_out_q, y_out_d;
  logic [CH_W-1:0]             out_ch_q, out_ch_d;
  logic                        out_valid_q, out_valid_d;

  logic signed [2*IN_W-1:0]    mul_x, mul_y;
  logic signed [ACC_W-1:0]     u_x, u_y, xn, yn;

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign X_out     = x_out_q;
  assign Y_out     = y_out_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

  // Full-precision mixer products for the channel being processed.
  always_comb begin
    mul_x = sig_q * $signed(cos_q[ch_q]);
    mul_y = sig_q * $signed(sin_q[ch_q]);
  end

  // Stage 0 takes the mixer output; later stages chain off the stage just updated.
  always_comb begin
    u_x = px_q;
    u_y = py_q;
    if (s_q != '0) begin
      u_x = yx_q[ch_q][s_q - ORD_W'(1)];
      u_y = yy_q[ch_q][s_q - ORD_W'(1)];
    end
  end

  lockin_lpf_stage #(.ACC_W(ACC_W), .ALPHA_W(ALPHA_W)) u_lpf_x (
    .u      (u_x),
    .y      (yx_q[ch_q][s_q]),
    .alpha  (alpha_q),
    .y_next (xn)
  );

  lockin_lpf_stage #(.ACC_W(ACC_W), .ALPHA_W(ALPHA_W)) u_lpf_y (
    .u      (u_y),
    .y      (yy_q[ch_q][s_q]),
    .alpha  (alpha_q),
    .y_next (yn)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    s_d         = s_q;
    k_d         = k_q;
    alpha_d     = alpha_q;
    sig_d       = sig_q;
    cos_d       = cos_q;
    sin_d       = sin_q;
    px_d        = px_q;
    py_d        = py_q;
    yx_d        = yx_q;
    yy_d        = yy_q;
    x_out_d     = x_out_q;
    y_out_d     = y_out_q;
    out_ch_d    = out_ch_q;
    out_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sig_d   = signal_in;
          cos_d   = cos_ref;
          sin_d   = sin_ref;
          alpha_d = alpha;
          k_d     = ORD_W'(clamp_order(32'(filter_order), MAX_ORDER));
          ch_d    = '0;
          state_d = ST_MIX;
        end
      end
      ST_MIX: begin
        px_d    = ACC_W'(mul_x);
        py_d    = ACC_W'(mul_y);
        s_d     = '0;
        state_d = ST_FILT;
      end
      ST_FILT: begin
        yx_d[ch_q][s_q] = xn;
        yy_d[ch_q][s_q] = yn;
        if (s_q == k_q) begin
          x_out_d     = xn;
          y_out_d     = yn;
          out_ch_d    = ch_q;
          out_valid_d = 1'b1;
          state_d     = ST_EMIT;
        end else begin
          s_d = s_q + ORD_W'(1);
        end
      end
      ST_EMIT: begin
        if (ch_q == CH_W'(N_CH - 1)) begin
          state_d = ST_IDLE;
        end else begin
          ch_d    = ch_q + CH_W'(1);
          state_d = ST_MIX;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Clear wins over any transfer or pending strobe.
    if (filter_clear) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      for (int c = 0; c < int'(N_CH); c++) begin
        for (int s = 0; s < int'(MAX_ORDER); s++) begin
          yx_d[c][s] = '0;
          yy_d[c][s] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ch_q        <= '0;
      s_q         <= '0;
      k_q         <= '0;
      alpha_q     <= '0;
      sig_q       <= '0;
      cos_q       <= '0;
      sin_q       <= '0;
      px_q        <= '0;
      py_q        <= '0;
      x_out_q     <= '0;
      y_out_q     <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      for (int c = 0; c < int'(N_CH); c++) begin
        for (int s = 0; s < int'(MAX_ORDER); s++) begin
          yx_q[c][s] <= '0;
          yy_q[c][s] <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      s_q         <= s_d;
      k_q         <= k_d;
      alpha_q     <= alpha_d;
      sig_q       <= sig_d;
      cos_q       <= cos_d;
      sin_q       <= sin_d;
      px_q        <= px_d;
      py_q        <= py_d;
      x_out_q     <= x_out_d;
      y_out_q     <= y_out_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      yx_q        <= yx_d;
      yy_q        <= yy_d;
    end
  end

endmodule

// File: tb/tb_lockin_multi.sv
// Directed bench for lockin_multi: vector table for filter arithmetic plus
// hand-written sequences for timing, reset abort and clear priority.
module tb_lockin_multi;

  localparam int unsigned A_HALF = 67108864;   // 0.5 in Q0.27
  localparam int unsigned A_MAX  = 134217727;  // largest coefficient

  logic                     clk_50MHz = 1'b0;
  logic                     rst;
  logic signed [15:0]       signal_in;
  logic [1:0][15:0]         cos_ref;
  logic [1:0][15:0]         sin_ref;
  logic                     in_valid;
  logic                     in_ready;
  logic [1:0]               filter_order;
  logic [26:0]              alpha;
  logic                     filter_clear;
  logic signed [31:0]       x_out;
  logic signed [31:0]       y_out;
  logic                     out_ch;
  logic                     out_valid;

  int n_tests = 0;
  int n_fail  = 0;

  longint got_x [2];
  longint got_y [2];
  int     got_ch [2];
  int     got_n;

  typedef struct {
    bit     clr;
    int     k;
    int     a;
    int     sig, c0, s0, c1, s1;
    longint x0, y0, x1, y1;
  } vec_t;

  vec_t vecs [9];

  always #10 clk_50MHz = ~clk_50MHz;

  lockin_multi dut (
    .clk_50MHz    (clk_50MHz),
    .rst          (rst),
    .signal_in    (signal_in),
    .cos_ref      (cos_ref),
    .sin_ref      (sin_ref),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .filter_order (filter_order),
    .alpha        (alpha),
    .filter_clear (filter_clear),
    .X_out        (x_out),
    .Y_out        (y_out),
    .out_ch       (out_ch),
    .out_valid    (out_valid)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_clear();
    @(negedge clk_50MHz);
    filter_clear = 1'b1;
    @(negedge clk_50MHz);
    filter_clear = 1'b0;
  endtask

  // One transfer; afterwards the inputs are scrambled to prove they were latched.
  task automatic send(input int k, input int a, input int sig,
                      input int c0, input int s0, input int c1, input int s1);
    int w;
    w = 0;
    @(negedge clk_50MHz);
    while (!in_ready && w < 50) begin
      @(negedge clk_50MHz);
      w++;
    end
    if (!in_ready) check("send_ready_timeout", 0, 1);
    filter_order = 2'(k);
    alpha        = 27'(a);
    signal_in    = 16'(sig);
    cos_ref[0]   = 16'(c0);
    sin_ref[0]   = 16'(s0);
    cos_ref[1]   = 16'(c1);
    sin_ref[1]   = 16'(s1);
    in_valid     = 1'b1;
    @(posedge clk_50MHz);
    @(negedge clk_50MHz);
    in_valid     = 1'b0;
    signal_in    = 16'h7abc;
    cos_ref      = {16'h1234, 16'h4321};
    sin_ref      = {16'h5555, 16'h2222};
    alpha        = 27'h3ffffff;
    filter_order = 2'd3;
  endtask

  // Gather the two channel strobes within a bounded window.
  task automatic collect();
    got_n = 0;
    for (int i = 0; i < 60 && got_n < 2; i++) begin
      if (out_valid) begin
        got_x[got_n]  = longint'(x_out);
        got_y[got_n]  = longint'(y_out);
        got_ch[got_n] = int'(out_ch);
        got_n++;
      end
      if (got_n < 2) @(negedge clk_50MHz);
    end
    check("strobe_count", got_n, 2);
    if (got_n < 2) begin
      got_x  = '{default: 0};
      got_y  = '{default: 0};
      got_ch = '{default: 0};
    end
  endtask

  initial begin
    logic [11:0] v_mask, r_mask;
    logic        ch5, ch10;
    int          extra;

    //            clr k  alpha   sig     c0      s0     c1     s1     x0         y0          x1       y1
    vecs[0] = '{1'b1, 0, A_HALF, 1000,   1000,   0,     0,     -500,  500000,    0,          0,       -250000};
    vecs[1] = '{1'b0, 0, A_HALF, 1000,   1000,   0,     0,     -500,  750000,    0,          0,       -375000};
    vecs[2] = '{1'b1, 1, A_HALF, 1000,   1000,   0,     0,     0,     250000,    0,          0,       0};
    vecs[3] = '{1'b0, 1, A_HALF, 1000,   1000,   0,     0,     0,     500000,    0,          0,       0};
    vecs[4] = '{1'b1, 0, A_HALF, -3,     1,      3,     0,     0,     -2,        -5,         0,       0};
    vecs[5] = '{1'b1, 3, 0,      100,    100,    100,   100,   -100,  0,         0,          0,       0};
    vecs[6] = '{1'b1, 0, A_MAX,  1000,   1000,   -1000, 0,     0,     999999,    -1000000,   0,       0};
    vecs[7] = '{1'b1, 2, A_HALF, 1000,   1000,   0,     -2000, 0,     125000,    0,          -250000, 0};
    vecs[8] = '{1'b1, 0, A_HALF, -32768, -32768, 32767, 1,     -1,    536870912, -536854528, -16384,  16384};

    rst = 1'b1; in_valid = 1'b0; filter_clear = 1'b0;
    signal_in = '0; cos_ref = '0; sin_ref = '0; filter_order = '0; alpha = '0;
    repeat (3) @(negedge clk_50MHz);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_x_out", x_out, 0);
    check("rst_y_out", y_out, 0);
    check("rst_out_ch", out_ch, 0);
    rst = 1'b0;
    @(negedge clk_50MHz);
    check("post_rst_in_ready", in_ready, 1);

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].clr) do_clear();
      send(vecs[i].k, vecs[i].a, vecs[i].sig, vecs[i].c0, vecs[i].s0, vecs[i].c1, vecs[i].s1);
      collect();
      check($sformatf("v%0d_ch_a", i), got_ch[0], 0);
      check($sformatf("v%0d_ch_b", i), got_ch[1], 1);
      check($sformatf("v%0d_x0", i), got_x[0], vecs[i].x0);
      check($sformatf("v%0d_y0", i), got_y[0], vecs[i].y0);
      check($sformatf("v%0d_x1", i), got_x[1], vecs[i].x1);
      check($sformatf("v%0d_y1", i), got_y[1], vecs[i].y1);
    end

    // Strobe/ready timing for k = 2 with in_valid held high throughout.
    do_clear();
    @(negedge clk_50MHz);
    filter_order = 2'd2; alpha = 27'(A_HALF); signal_in = 16'sd1000;
    cos_ref = {16'd0, 16'd1000}; sin_ref = '0;
    in_valid = 1'b1;
    @(posedge clk_50MHz);
    v_mask = '0; r_mask = '0; ch5 = 1'b1; ch10 = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk_50MHz);
      v_mask[i] = out_valid;
      r_mask[i] = in_ready;
      if (i == 5)  ch5  = out_ch;
      if (i == 10) ch10 = out_ch;
      if (i == 11) in_valid = 1'b0;
    end
    check("timing_valid_mask", longint'(v_mask), longint'(12'b0100_0010_0000));
    check("timing_ready_mask", longint'(r_mask), longint'(12'b1000_0000_0000));
    check("timing_ch_at_5", ch5, 0);
    check("timing_ch_at_10", ch10, 1);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_50MHz);
      if (out_valid) extra++;
    end
    check("timing_no_extra_strobe", extra, 0);

    // Reset in the middle of a k = 2 sequence.
    do_clear();
    @(negedge clk_50MHz);
    filter_order = 2'd2; alpha = 27'(A_HALF); signal_in = 16'sd1000;
    cos_ref = {16'd0, 16'd1000}; sin_ref = '0;
    in_valid = 1'b1;
    @(posedge clk_50MHz);
    @(negedge clk_50MHz);
    in_valid = 1'b0;
    @(negedge clk_50MHz);
    @(negedge clk_50MHz);
    rst = 1'b1;
    @(negedge clk_50MHz);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_x_out", x_out, 0);
    check("midrst_y_out", y_out, 0);
    check("midrst_out_ch", out_ch, 0);
    rst = 1'b0;
    @(negedge clk_50MHz);
    check("midrst_ready_after", in_ready, 1);
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk_50MHz);
      if (out_valid) extra++;
    end
    check("midrst_no_strobe", extra, 0);

    // Clear beats a simultaneous transfer and restores a fresh filter.
    send(0, A_HALF, 1000, 1000, 0, 0, 0);
    collect();
    check("clr_pre_x0", got_x[0], 500000);
    @(negedge clk_50MHz);
    filter_clear = 1'b1; in_valid = 1'b1;
    filter_order = 2'd0; alpha = 27'(A_HALF); signal_in = 16'sd1000;
    cos_ref = {16'd0, 16'd1000}; sin_ref = '0;
    @(negedge clk_50MHz);
    check("clr_no_transfer", in_ready, 1);
    filter_clear = 1'b0; in_valid = 1'b0;
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_50MHz);
      if (out_valid) extra++;
    end
    check("clr_no_strobe", extra, 0);
    send(0, A_HALF, 1000, 1000, 0, 0, 0);
    collect();
    check("clr_post_x0", got_x[0], 500000);
    check("clr_post_y0", got_y[0], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
